// File: rtl/sqemux_switch_ctrl.sv
// sqemux_switch_ctrl
// Sequencer for the SQEMUX clock-mux control pins (SELECT/SEN/DEN).
// Each source change is break-before-make:
//   1. gate the mux off (SEN low),
//   2. wait GATE_CYCLES, then flip SELECT,
//   3. wait SETTLE_CYCLES, then re-enable (SEN high) and pulse DONE.
// After reset the mux stays gated for SETTLE_CYCLES before it is first enabled.
// All outputs are flops clocked by the free-running control clock CLK.
module sqemux_switch_ctrl #(
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_VALID,
  input  logic REQ_SEL,
  output logic REQ_READY,
  input  logic DYNEN_IN,
  output logic SELECT,
  output logic SEN,
  output logic DEN,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  localparam logic [1:0] ST_STARTUP  = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_GATE_OFF = 2'd2;
  localparam logic [1:0] ST_SETTLE   = 2'd3;

  // Terminal counts are pre-cast to the counter width so comparisons are width-exact.
  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             select_q, select_d;
  logic             sen_q,    sen_d;
  logic             den_q,    den_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;
  logic             target_q, target_d;
  logic             ready_q,  ready_d;
  logic             busy_q,   busy_d;

  // Next-state logic for the switch sequencer; DONE/ERR default low so they pulse for one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    select_d = select_q;
    sen_d    = sen_q;
    den_d    = den_q;
    target_d = target_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_STARTUP: begin
        if (cnt_q == SETTLE_LAST) begin
          sen_d   = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (REQ_VALID && ready_q) begin
          if (REQ_SEL == select_q) begin
            // Already on the requested source: acknowledge without touching the mux.
            done_d = 1'b1;
          end else if (!DYNEN_IN) begin
            // A switch is needed but dynamic switching is not permitted.
            err_d = 1'b1;
          end else begin
            // Start the switch: gate the mux off first.
            sen_d    = 1'b0;
            den_d    = 1'b1;
            target_d = REQ_SEL;
            cnt_d    = CNT_ZERO;
            state_d  = ST_GATE_OFF;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GATE_OFF: begin
        if (cnt_q == GATE_LAST) begin
          // SEN has been low for GATE_CYCLES, so SELECT can change safely.
          select_d = target_q;
          cnt_d    = CNT_ZERO;
          state_d  = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          // Re-enable on a later edge than the SELECT change.
          sen_d   = 1'b1;
          den_d   = 1'b0;
          done_d  = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        // Unreachable encoding: recover through the gated startup path.
        state_d = ST_STARTUP;
        cnt_d   = CNT_ZERO;
        sen_d   = 1'b0;
        den_d   = 1'b0;
      end
    endcase
  end

  // READY/BUSY are registered from the next state so they match the state flop exactly.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers. Reset is asynchronous and gates the mux immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_STARTUP;
      cnt_q    <= CNT_ZERO;
      select_q <= 1'b0;
      sen_q    <= 1'b0;
      den_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      target_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      select_q <= select_d;
      sen_q    <= sen_d;
      den_q    <= den_d;
      done_q   <= done_d;
      err_q    <= err_d;
      target_q <= target_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign REQ_READY = ready_q;
  assign BUSY      = busy_q;
  assign SELECT    = select_q;
  assign SEN       = sen_q;
  assign DEN       = den_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_sqemux_switch_ctrl.sv
// tb_sqemux_switch_ctrl
// Directed bench for sqemux_switch_ctrl.
// Three instances are built: 4/4 (defaults), 1/1 and 255/255 (GATE/SETTLE).
// Only one instance is exercised at a time; the others are held in reset.
module tb_sqemux_switch_ctrl;

  logic clk;
  logic rst       [3];
  logic req_valid [3];
  logic req_sel   [3];
  logic dynen     [3];
  logic ready     [3];
  logic select    [3];
  logic sen       [3];
  logic den       [3];
  logic busy      [3];
  logic done      [3];
  logic err       [3];
  logic prev_sel  [3];
  logic prev_sen  [3];

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sqemux_switch_ctrl #(.GATE_CYCLES(4), .SETTLE_CYCLES(4), .CNT_W(8)) u_dut0 (
    .CLK(clk), .RST(rst[0]), .REQ_VALID(req_valid[0]), .REQ_SEL(req_sel[0]),
    .REQ_READY(ready[0]), .DYNEN_IN(dynen[0]), .SELECT(select[0]), .SEN(sen[0]),
    .DEN(den[0]), .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0])
  );

  sqemux_switch_ctrl #(.GATE_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
    .CLK(clk), .RST(rst[1]), .REQ_VALID(req_valid[1]), .REQ_SEL(req_sel[1]),
    .REQ_READY(ready[1]), .DYNEN_IN(dynen[1]), .SELECT(select[1]), .SEN(sen[1]),
    .DEN(den[1]), .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1])
  );

  sqemux_switch_ctrl #(.GATE_CYCLES(255), .SETTLE_CYCLES(255), .CNT_W(8)) u_dut2 (
    .CLK(clk), .RST(rst[2]), .REQ_VALID(req_valid[2]), .REQ_SEL(req_sel[2]),
    .REQ_READY(ready[2]), .DYNEN_IN(dynen[2]), .SELECT(select[2]), .SEN(sen[2]),
    .DEN(den[2]), .BUSY(busy[2]), .DONE(done[2]), .ERR(err[2])
  );

  function automatic int g_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 255;
    endcase
  endfunction

  function automatic int s_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 255;
    endcase
  endfunction

  // Advance one edge and sample 1 time unit later.
  // Also checks, on every instance not in reset:
  //   - SELECT never changes unless SEN was low before and after the edge;
  //   - DONE and ERR are never high together.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!rst[k]) begin
        if (select[k] !== prev_sel[k]) begin
          n_checks++;
          if (prev_sen[k] !== 1'b0 || sen[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_vs_sen dut%0d: SELECT changed with SEN before=%b after=%b, required 0/0",
                     k, prev_sen[k], sen[k]);
          end
        end
        if (done[k] || err[k]) begin
          n_checks++;
          if (done[k] && err[k]) begin
            n_fail++;
            $display("FAIL done_err_excl dut%0d: DONE=%b ERR=%b, required not both", k, done[k], err[k]);
          end
        end
      end
      prev_sel[k] = select[k];
      prev_sen[k] = sen[k];
    end
  endtask

  // Reset, check the reset values, release, then walk the startup delay edge by edge.
  task automatic test_reset(input int k);
    int s;
    logic last;
    s = s_of(k);
    rst[k] = 1'b1;
    req_valid[k] = 1'b0;
    req_sel[k] = 1'b0;
    dynen[k] = 1'b0;
    tick();
    n_checks++;
    if ({select[k], sen[k], den[k], done[k], err[k], ready[k], busy[k]} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_state dut%0d: got %b, want 0000001", k,
               {select[k], sen[k], den[k], done[k], err[k], ready[k], busy[k]});
    end
    rst[k] = 1'b0;
    for (int i = 1; i <= s; i++) begin
      tick();
      last = (i == s);
      n_checks++;
      if ({sen[k], ready[k], busy[k], select[k], den[k]} !== {last, last, ~last, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL startup dut%0d edge %0d: got %b, want %b", k, i,
                 {sen[k], ready[k], busy[k], select[k], den[k]}, {last, last, ~last, 1'b0, 1'b0});
      end
    end
  endtask

  // Called right after the accepting edge E.
  // Follows the switch through GATE_OFF and SETTLE up to completion at E+G+S.
  task automatic track_switch(input int k, input logic to);
    int g;
    int s;
    logic exp_sel;
    logic last;
    g = g_of(k);
    s = s_of(k);
    n_checks++;
    if ({sen[k], den[k], ready[k], busy[k], done[k], select[k]} !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ~to}) begin
      n_fail++;
      $display("FAIL switch_start dut%0d: got %b, want %b", k,
               {sen[k], den[k], ready[k], busy[k], done[k], select[k]}, {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ~to});
    end
    for (int i = 1; i <= g; i++) begin
      tick();
      exp_sel = (i == g) ? to : ~to;
      n_checks++;
      if ({select[k], sen[k], den[k], ready[k]} !== {exp_sel, 1'b0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL gate_off dut%0d edge E+%0d: got %b, want %b", k, i,
                 {select[k], sen[k], den[k], ready[k]}, {exp_sel, 1'b0, 1'b1, 1'b0});
      end
    end
    for (int i = 1; i <= s; i++) begin
      tick();
      last = (i == s);
      n_checks++;
      if ({sen[k], den[k], done[k], ready[k], busy[k], select[k]} !== {last, ~last, last, last, ~last, to}) begin
        n_fail++;
        $display("FAIL settle dut%0d edge E+%0d: got %b, want %b", k, g + i,
                 {sen[k], den[k], done[k], ready[k], busy[k], select[k]}, {last, ~last, last, last, ~last, to});
      end
    end
  endtask

  // One complete switch to source 'to', then confirm DONE drops after one cycle.
  task automatic test_switch(input int k, input logic to);
    req_valid[k] = 1'b1;
    req_sel[k] = to;
    dynen[k] = 1'b1;
    tick();
    req_valid[k] = 1'b0;
    track_switch(k, to);
    tick();
    n_checks++;
    if ({done[k], ready[k], select[k], sen[k]} !== {1'b0, 1'b1, to, 1'b1}) begin
      n_fail++;
      $display("FAIL switch_end dut%0d: got %b, want %b", k,
               {done[k], ready[k], select[k], sen[k]}, {1'b0, 1'b1, to, 1'b1});
    end
  endtask

  // Request the source that is already selected: DONE pulse only, mux untouched.
  task automatic test_same_source(input int k, input logic cur);
    req_valid[k] = 1'b1;
    req_sel[k] = cur;
    dynen[k] = 1'b0;
    tick();
    req_valid[k] = 1'b0;
    n_checks++;
    if ({done[k], err[k], sen[k], select[k], den[k], ready[k]} !== {1'b1, 1'b0, 1'b1, cur, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL same_source dut%0d: got %b, want %b", k,
               {done[k], err[k], sen[k], select[k], den[k], ready[k]}, {1'b1, 1'b0, 1'b1, cur, 1'b0, 1'b1});
    end
    tick();
    n_checks++;
    if ({done[k], sen[k], select[k]} !== {1'b0, 1'b1, cur}) begin
      n_fail++;
      $display("FAIL same_source_end dut%0d: got %b, want %b", k,
               {done[k], sen[k], select[k]}, {1'b0, 1'b1, cur});
    end
  endtask

  // Request a different source with DYNEN_IN low: ERR pulse, nothing else changes.
  task automatic test_reject(input int k, input logic cur);
    req_valid[k] = 1'b1;
    req_sel[k] = ~cur;
    dynen[k] = 1'b0;
    tick();
    req_valid[k] = 1'b0;
    n_checks++;
    if ({err[k], done[k], select[k], sen[k], den[k], ready[k]} !== {1'b1, 1'b0, cur, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reject dut%0d: got %b, want %b", k,
               {err[k], done[k], select[k], sen[k], den[k], ready[k]}, {1'b1, 1'b0, cur, 1'b1, 1'b0, 1'b1});
    end
    tick();
    n_checks++;
    if ({err[k], select[k], sen[k]} !== {1'b0, cur, 1'b1}) begin
      n_fail++;
      $display("FAIL reject_end dut%0d: got %b, want %b", k, {err[k], select[k], sen[k]}, {1'b0, cur, 1'b1});
    end
  endtask

  // After acceptance DYNEN_IN drops and REQ_SEL flips; the 0->1 switch must still complete.
  task automatic test_disturb(input int k);
    req_valid[k] = 1'b1;
    req_sel[k] = 1'b1;
    dynen[k] = 1'b1;
    tick();
    req_valid[k] = 1'b0;
    req_sel[k] = 1'b0;
    dynen[k] = 1'b0;
    track_switch(k, 1'b1);
  endtask

  // Reset asserted at E+5: outputs must clear immediately, then startup reruns.
  task automatic test_reset_mid(input int k);
    req_valid[k] = 1'b1;
    req_sel[k] = 1'b1;
    dynen[k] = 1'b1;
    tick();
    req_valid[k] = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ({select[k], sen[k], den[k]} !== 3'b101) begin
      n_fail++;
      $display("FAIL mid_switch_pre dut%0d: got %b, want 101", k, {select[k], sen[k], den[k]});
    end
    rst[k] = 1'b1;
    #1;
    n_checks++;
    if ({select[k], sen[k], den[k], ready[k], busy[k]} !== 5'b00001) begin
      n_fail++;
      $display("FAIL async_reset dut%0d: got %b, want 00001", k,
               {select[k], sen[k], den[k], ready[k], busy[k]});
    end
    test_reset(k);
  endtask

  // Back-to-back 0->1->0 switches.
  // REQ_VALID stays high with REQ_SEL=0 throughout the first switch.
  // That held request is ignored until READY returns, and is then taken on the edge after DONE.
  task automatic test_back_to_back(input int k);
    req_valid[k] = 1'b1;
    req_sel[k] = 1'b1;
    dynen[k] = 1'b1;
    tick();
    req_sel[k] = 1'b0;
    track_switch(k, 1'b1);
    tick();
    req_valid[k] = 1'b0;
    track_switch(k, 1'b0);
    tick();
    n_checks++;
    if ({done[k], ready[k], select[k], sen[k], den[k]} !== 5'b01010) begin
      n_fail++;
      $display("FAIL back_to_back_end dut%0d: got %b, want 01010", k,
               {done[k], ready[k], select[k], sen[k], den[k]});
    end
  endtask

  // Stimulus sequence: all scenarios on the 4/4 instance, then back-to-back on 1/1 and 255/255.
  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      req_valid[k] = 1'b0;
      req_sel[k] = 1'b0;
      dynen[k] = 1'b0;
      prev_sel[k] = 1'b0;
      prev_sen[k] = 1'b0;
    end
    test_reset(0);
    test_same_source(0, 1'b0);
    test_reject(0, 1'b0);
    test_switch(0, 1'b1);
    test_same_source(0, 1'b1);
    test_reject(0, 1'b1);
    test_switch(0, 1'b0);
    test_disturb(0);
    test_switch(0, 1'b0);
    test_reset_mid(0);
    test_back_to_back(0);
    rst[0] = 1'b1;
    test_reset(1);
    test_back_to_back(1);
    rst[1] = 1'b1;
    test_reset(2);
    test_back_to_back(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
